wash_sequencer: RTL

- Program controller for the washer.
- Latches the selected program code `model_now` (0..5) when a run starts.
- Steps through the wash, rinse and spin phases using 1-second ticks, and drives the fill, motor and drain actuators.
- Pulses `if_finish` at the end of the program; the mode selector uses this pulse to return to its default program.

---
 rtl/wash_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wash_sequencer.sv
// Washer program controller: latches a program code on start, sequences the
// wash/rinse/spin phases on 1 s ticks and drives the fill, motor and drain actuators.
module wash_sequencer #(
  parameter int WASH_S  = 10,
  parameter int RINSE_S = 6,
  parameter int SPIN_S  = 4,
  parameter int FILL_S  = 2,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          power_led,
  input  logic          start_pause,
  input  logic          tick_1s,
  input  logic [2:0]    model_now,
  output logic [1:0]    phase,
  output logic [TW-1:0] remain_s,
  output logic          water_in,
  output logic          motor_on,
  output logic          drain,
  output logic          running,
  output logic          if_finish
);

  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_DONE} state_t;

  localparam logic [TW-1:0] WASH_LEN  = TW'(WASH_S);
  localparam logic [TW-1:0] RINSE_LEN = TW'(RINSE_S);
  localparam logic [TW-1:0] SPIN_LEN  = TW'(SPIN_S);
  localparam logic [TW-1:0] FILL_LEN  = TW'(FILL_S);

  generate
    if (WASH_S + RINSE_S + SPIN_S > (1 << TW) - 1) begin : g_tw_check
      $error("wash_sequencer: TW too narrow for the longest program");
    end
    if (FILL_S >= WASH_S || FILL_S >= RINSE_S) begin : g_fill_check
      $error("wash_sequencer: FILL_S must be shorter than wash and rinse");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [2:0]    prog_q, prog_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] remain_q, remain_d;
  state_t        first_st, next_st;
  logic [TW-1:0] elapsed;

  function automatic state_t first_phase(input logic [2:0] p);
    case (p)
      3'd0, 3'd1, 3'd2: first_phase = S_WASH;
      3'd3, 3'd4:       first_phase = S_RINSE;
      default:          first_phase = S_SPIN;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s, input logic [2:0] p);
    case (s)
      S_WASH:  next_phase = (p == 3'd0 || p == 3'd2) ? S_RINSE : S_DONE;
      S_RINSE: next_phase = (p == 3'd0 || p == 3'd3) ? S_SPIN : S_DONE;
      default: next_phase = S_DONE;
    endcase
  endfunction

  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      S_WASH:  phase_len = WASH_LEN;
      S_RINSE: phase_len = RINSE_LEN;
      S_SPIN:  phase_len = SPIN_LEN;
      default: phase_len = '0;
    endcase
  endfunction

  function automatic logic [TW-1:0] prog_total(input logic [2:0] p);
    case (p)
      3'd0:    prog_total = WASH_LEN + RINSE_LEN + SPIN_LEN;
      3'd1:    prog_total = WASH_LEN;
      3'd2:    prog_total = WASH_LEN + RINSE_LEN;
      3'd3:    prog_total = RINSE_LEN + SPIN_LEN;
      3'd4:    prog_total = RINSE_LEN;
      3'd5:    prog_total = SPIN_LEN;
      default: prog_total = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      prog_q   <= '0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      prog_q   <= prog_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    first_st = first_phase(model_now);
    next_st  = next_phase(state_q, prog_q);

    // Releasing start while idle re-arms; a held button cannot restart a finished run.
    if (state_q == S_IDLE && !start_pause) armed_d = 1'b1;

    if (!power_led) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      remain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pause && armed_q && model_now <= 3'd5) begin
            prog_d   = model_now;
            armed_d  = 1'b0;
            state_d  = first_st;
            cnt_d    = phase_len(first_st);
            remain_d = prog_total(model_now);
          end
        end
        S_WASH, S_RINSE, S_SPIN: begin
          if (start_pause && tick_1s) begin
            remain_d = (remain_q != '0) ? remain_q - TW'(1) : '0;
            if (cnt_q <= TW'(1)) begin
              state_d = next_st;
              cnt_d   = phase_len(next_st);
            end else begin
              cnt_d = cnt_q - TW'(1);
            end
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          remain_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    phase     = 2'd0;
    running   = 1'b0;
    water_in  = 1'b0;
    motor_on  = 1'b0;
    drain     = 1'b0;
    if_finish = (state_q == S_DONE);
    remain_s  = remain_q;
    elapsed   = phase_len(state_q) - cnt_q;
    case (state_q)
      S_WASH:  begin phase = 2'd1; running = 1'b1; end
      S_RINSE: begin phase = 2'd2; running = 1'b1; end
      S_SPIN:  begin phase = 2'd3; running = 1'b1; end
      default: ;
    endcase
    if (start_pause) begin
      case (state_q)
        S_WASH, S_RINSE: begin
          if (elapsed < FILL_LEN) water_in = 1'b1;
          else                    motor_on = 1'b1;
        end
        S_SPIN: begin
          drain    = 1'b1;
          motor_on = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
